// File: rtl/bank_reg_param.sv
// Clocked register bank: 2**AW x WIDTH, two registered read ports, one write port,
// hardware clear sweep after reset/Clr. Optional write-first bypass: BANKR_BYPASS_EN.
module bank_reg_param #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Rw,
  input  logic [AW-1:0]    Dir,
  input  logic [WIDTH-1:0] DIn,
  input  logic [AW-1:0]    Rd1,
  input  logic [AW-1:0]    Rd2,
  input  logic             Clr,
  output logic [WIDTH-1:0] L1,
  output logic [WIDTH-1:0] L2,
  output logic             Busy
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] l1_q, l1_d, l2_q, l2_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             wr_en;
  logic [WIDTH-1:0] rd1_data, rd2_data;

  // Entry 0 is forced to zero on the read side so it never depends on array contents.
  assign rd1_data = (ZERO_R0 != 0 && Rd1 == '0) ? '0 : mem_q[Rd1];
  assign rd2_data = (ZERO_R0 != 0 && Rd2 == '0) ? '0 : mem_q[Rd2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    l1_d      = '0;
    l2_d      = '0;
    wr_en     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = Dir;
    mem_wdata = DIn;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (Clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (Rw && !(ZERO_R0 != 0 && Dir == '0)) begin
          wr_en = 1'b1;
        end
        mem_we = wr_en;
        l1_d   = rd1_data;
        l2_d   = rd2_data;
`ifdef BANKR_BYPASS_EN
        if (wr_en && Dir == Rd1) l1_d = DIn;
        if (wr_en && Dir == Rd2) l2_d = DIn;
`endif
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign L1   = l1_q;
  assign L2   = l2_q;
  assign Busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_bank_reg_param.sv
// Directed bench for bank_reg_param; read expectations go through a scoreboard queue.
module tb_bank_reg_param;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Rw = 1'b0;
  logic [4:0]  Dir = '0;
  logic [31:0] DIn = '0;
  logic [4:0]  Rd1 = '0;
  logic [4:0]  Rd2 = '0;
  logic        Clr = 1'b0;
  logic [31:0] L1, L2;
  logic        Busy;

  int unsigned n_asserts = 0;
  int unsigned n_fails   = 0;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb;
  } exp_t;

  exp_t sb[$];

  bank_reg_param #(.WIDTH(32), .AW(5), .ZERO_R0(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rw(Rw), .Dir(Dir), .DIn(DIn),
    .Rd1(Rd1), .Rd2(Rd2), .Clr(Clr), .L1(L1), .L2(L2), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of stimulus; when chk_en, expectations for the next edge are queued.
  task automatic step(input logic rw, input logic [4:0] dir, input logic [31:0] din,
                      input logic [4:0] r1, input logic [4:0] r2, input logic clr,
                      input bit chk_en, input string tag,
                      input logic [31:0] e1, input logic [31:0] e2, input logic eb);
    exp_t e;
    Rw = rw; Dir = dir; DIn = din; Rd1 = r1; Rd2 = r2; Clr = clr;
    if (chk_en) begin
      e.tag = tag; e.e1 = e1; e.e2 = e2; e.eb = eb;
      sb.push_back(e);
    end
    @(posedge Clk);
    #1;
    if (chk_en) begin
      e = sb.pop_front();
      chk({e.tag, ".L1"}, L1, e.e1);
      chk({e.tag, ".L2"}, L2, e.e2);
      chk({e.tag, ".Busy"}, {31'd0, Busy}, {31'd0, e.eb});
    end
  endtask

  task automatic busy_edges(input string tag, input int exp_n);
    int n = 0;
    while (Busy === 1'b1 && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    // Reset state, then the full post-reset sweep.
    #12;
    chk("rst.Busy", {31'd0, Busy}, 32'd1);
    chk("rst.L1", L1, 32'h0);
    chk("rst.L2", L2, 32'h0);
    Rst_n = 1'b1;
    busy_edges("rst.sweep_len", 32);

    for (int a = 0; a < 32; a++)
      step(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b0, 1'b1, "clr_read", 32'h0, 32'h0, 1'b0);

    // Basic write then read on both ports.
    step(1'b1, 5'd7, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0, 1'b0, "", '0, '0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 1'b1, "basic", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

    // Entry 0 hardwired: the write is dropped, no bypass either.
    step(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b1, "zero_same", 32'h0, 32'h0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 1'b1, "zero_after", 32'h0, 32'hDEADBEEF, 1'b0);

    // Same-edge hazard on port 1; port 2 reads an untouched cleared entry.
    step(1'b1, 5'd3, 32'h11111111, 5'd0, 5'd0, 1'b0, 1'b0, "", '0, '0, 1'b0);
`ifdef BANKR_BYPASS_EN
    step(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd5, 1'b0, 1'b1, "hazard", 32'hA5A5A5A5, 32'h0, 1'b0);
`else
    step(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd5, 1'b0, 1'b1, "hazard", 32'h11111111, 32'h0, 1'b0);
`endif
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 1'b1, "hazard_next", 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);

    // Clr collides with a write: clear wins, writes during the sweep are ignored.
    step(1'b1, 5'd9, 32'h55, 5'd0, 5'd0, 1'b0, 1'b0, "", '0, '0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 1'b0, 1'b1, "pre_clr", 32'h55, 32'hDEADBEEF, 1'b0);
    step(1'b1, 5'd9, 32'h77, 5'd9, 5'd7, 1'b1, 1'b1, "clr_edge", 32'h55, 32'hDEADBEEF, 1'b1);
    for (int k = 1; k <= 32; k++)
      step(1'b1, 5'd9, 32'h99, 5'd9, 5'd7, 1'b1, 1'b1, "clr_busy", 32'h0, 32'h0, (k < 32));
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 1'b0, 1'b1, "post_clr", 32'h0, 32'h0, 1'b0);

    // Reset in the middle of a sweep restarts it from entry 0.
    step(1'b1, 5'd4, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0, 1'b0, "", '0, '0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 1'b1, "pre_mid", 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 1'b1, "mid_clr", 32'hCAFEF00D, 32'hCAFEF00D, 1'b1);
    for (int k = 0; k < 10; k++)
      step(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 1'b1, "mid_busy", 32'h0, 32'h0, 1'b1);
    Rst_n = 1'b0;
    #2;
    chk("mid_rst.Busy", {31'd0, Busy}, 32'd1);
    chk("mid_rst.L1", L1, 32'h0);
    chk("mid_rst.L2", L2, 32'h0);
    #2;
    Rst_n = 1'b1;
    busy_edges("mid_rst.sweep_len", 32);
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd31, 1'b0, 1'b1, "post_mid", 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
